// File: rtl/rf_wb_arb.sv
// Write-back arbiter in front of the register-file write port: merges an in-order primary stream
// with a FIFO-buffered secondary stream, bounding secondary starvation with an aging counter.
module rf_wb_arb #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_p_valid,
    input  logic [4:0]  i_p_rd,
    input  logic [31:0] i_p_data,
    output logic        o_p_stall,
    input  logic        i_s_valid,
    output logic        o_s_ready,
    input  logic [4:0]  i_s_rd,
    input  logic [31:0] i_s_data,
    output logic        o_rd_wen,
    output logic [4:0]  o_rd_waddr,
    output logic [31:0] o_rd_wdata
);

    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int WW  = $clog2(MAX_WAIT + 1);
    localparam int WW1 = WW + 1;

    localparam logic [0:0]    ST_NORMAL  = 1'b0;
    localparam logic [0:0]    ST_FORCE   = 1'b1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
    localparam logic [WW:0]   WAIT_LIMIT = WW1'(MAX_WAIT);

    logic [0:0]    state_r, state_nxt_s;
    logic [WW-1:0] wait_r, wait_nxt_s;
    logic [WW:0]   wait_inc_s;
    logic [PW-1:0] wr_ptr_r, rd_ptr_r;
    logic [CW-1:0] count_r;
    logic [4:0]    mem_rd_r   [DEPTH];
    logic [31:0]   mem_data_r [DEPTH];

    logic        empty_s, full_s, push_s, pop_s;
    logic        grant_s, grant_p_s;
    logic [4:0]  grant_rd_s;
    logic [31:0] grant_data_s;
    logic        wen_r;
    logic [4:0]  waddr_r;
    logic [31:0] wdata_r;

    assign empty_s    = (count_r == {CW{1'b0}});
    assign full_s     = (count_r == FULL_CNT);
    assign push_s     = i_s_valid && !full_s;
    assign wait_inc_s = {1'b0, wait_r} + WW1'(1);

    assign o_p_stall  = (state_r == ST_FORCE);
    assign o_s_ready  = !full_s;
    assign o_rd_wen   = wen_r;
    assign o_rd_waddr = waddr_r;
    assign o_rd_wdata = wdata_r;

    // Grant selection, FSM next state and aging counter update.
    always_comb begin
        pop_s        = 1'b0;
        grant_s      = 1'b0;
        grant_p_s    = 1'b0;
        grant_rd_s   = 5'd0;
        grant_data_s = 32'd0;
        state_nxt_s  = ST_NORMAL;
        wait_nxt_s   = wait_r;
        case (state_r)
            ST_NORMAL: begin
                if (i_p_valid) begin
                    grant_s      = 1'b1;
                    grant_p_s    = 1'b1;
                    grant_rd_s   = i_p_rd;
                    grant_data_s = i_p_data;
                end else if (!empty_s) begin
                    grant_s      = 1'b1;
                    pop_s        = 1'b1;
                    grant_rd_s   = mem_rd_r[rd_ptr_r];
                    grant_data_s = mem_data_r[rd_ptr_r];
                end else begin
                    grant_s = 1'b0;
                end
            end
            ST_FORCE: begin
                // FORCE is only entered with the FIFO non-empty; the guard is defensive.
                if (!empty_s) begin
                    grant_s      = 1'b1;
                    pop_s        = 1'b1;
                    grant_rd_s   = mem_rd_r[rd_ptr_r];
                    grant_data_s = mem_data_r[rd_ptr_r];
                end else begin
                    grant_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_NORMAL;
            end
        endcase
        if (pop_s) begin
            wait_nxt_s = {WW{1'b0}};
        end else if (!empty_s && grant_p_s) begin
            if (wait_inc_s == WAIT_LIMIT) begin
                wait_nxt_s  = {WW{1'b0}};
                state_nxt_s = ST_FORCE;
            end else begin
                wait_nxt_s = wait_inc_s[WW-1:0];
            end
        end else begin
            wait_nxt_s = wait_r;
        end
    end

    // FSM state and aging counter registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_NORMAL;
            wait_r  <= {WW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            wait_r  <= wait_nxt_s;
        end
    end

    // Secondary FIFO storage, pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_rd_r[i]   <= 5'd0;
                mem_data_r[i] <= 32'd0;
            end
        end else begin
            if (push_s) begin
                mem_rd_r[wr_ptr_r]   <= i_s_rd;
                mem_data_r[wr_ptr_r] <= i_s_data;
                wr_ptr_r             <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Registered rf write port; address/data hold when no write is issued.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wen_r   <= 1'b0;
            waddr_r <= 5'd0;
            wdata_r <= 32'd0;
        end else begin
            wen_r <= grant_s && (grant_rd_s != 5'd0);
            if (grant_s && (grant_rd_s != 5'd0)) begin
                waddr_r <= grant_rd_s;
                wdata_r <= grant_data_s;
            end
        end
    end

endmodule

// File: tb/tb_rf_wb_arb.sv
// Directed testbench for rf_wb_arb (DEPTH=2, MAX_WAIT=4) with hand-computed expectations.
module tb_rf_wb_arb;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_p_valid = 1'b0;
    logic [4:0]  i_p_rd = 5'd0;
    logic [31:0] i_p_data = 32'd0;
    logic        o_p_stall;
    logic        i_s_valid = 1'b0;
    logic        o_s_ready;
    logic [4:0]  i_s_rd = 5'd0;
    logic [31:0] i_s_data = 32'd0;
    logic        o_rd_wen;
    logic [4:0]  o_rd_waddr;
    logic [31:0] o_rd_wdata;

    int checks = 0;
    int failures = 0;

    rf_wb_arb #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_p_valid(i_p_valid), .i_p_rd(i_p_rd), .i_p_data(i_p_data), .o_p_stall(o_p_stall),
        .i_s_valid(i_s_valid), .o_s_ready(o_s_ready), .i_s_rd(i_s_rd), .i_s_data(i_s_data),
        .o_rd_wen(o_rd_wen), .o_rd_waddr(o_rd_waddr), .o_rd_wdata(o_rd_wdata)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_p_valid = 1'b0; i_p_rd = 5'd0; i_p_data = 32'd0;
        i_s_valid = 1'b0; i_s_rd = 5'd0; i_s_data = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_rst_n = 1'b0;
        tick();
        tick();
        i_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        i_p_valid = 1'b1; i_p_rd = 5'd3; i_p_data = 32'h33;
        i_s_valid = 1'b1; i_s_rd = 5'd4; i_s_data = 32'h44;
        tick();
        i_s_rd = 5'd6; i_s_data = 32'h66;
        tick();
        checks++;
        if ({o_rd_wen, o_s_ready} !== 2'b10) begin
            failures++; $display("FAIL reset_pre wen/ready got=%b exp=10", {o_rd_wen, o_s_ready});
        end
        #2 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_rd_wen, o_s_ready, o_p_stall, o_rd_waddr, o_rd_wdata} !== {1'b0, 1'b1, 1'b0, 5'd0, 32'd0}) begin
            failures++;
            $display("FAIL reset_async got wen=%b ready=%b stall=%b addr=%0d data=%h exp 0 1 0 0 0",
                     o_rd_wen, o_s_ready, o_p_stall, o_rd_waddr, o_rd_wdata);
        end
        idle_inputs();
        tick();
        i_rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({o_rd_wen, o_s_ready} !== 2'b01) begin
                failures++; $display("FAIL reset_no_stale cyc=%0d got=%b exp=01", i, {o_rd_wen, o_s_ready});
            end
        end
    endtask

    task automatic test_primary();
        do_reset();
        i_p_valid = 1'b1; i_p_rd = 5'd5; i_p_data = 32'hDEAD_BEEF;
        tick();
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b1, 5'd5, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL primary_write got=%b/%0d/%h exp=1/5/deadbeef", o_rd_wen, o_rd_waddr, o_rd_wdata);
        end
        i_p_rd = 5'd0; i_p_data = 32'h1234_5678;
        tick();
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
            failures++; $display("FAIL primary_rd0 got=%b/%0d/%h exp=0/5/deadbeef", o_rd_wen, o_rd_waddr, o_rd_wdata);
        end
        idle_inputs();
        tick();
        checks++;
        if (o_rd_wen !== 1'b0) begin
            failures++; $display("FAIL primary_idle wen got=%b exp=0", o_rd_wen);
        end
    endtask

    task automatic test_secondary();
        do_reset();
        i_s_valid = 1'b1; i_s_rd = 5'd7; i_s_data = 32'h11;
        tick();
        i_s_rd = 5'd8; i_s_data = 32'h22;
        tick();
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b1, 5'd7, 32'h11}) begin
            failures++; $display("FAIL sec_first got=%b/%0d/%h exp=1/7/11", o_rd_wen, o_rd_waddr, o_rd_wdata);
        end
        idle_inputs();
        tick();
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b1, 5'd8, 32'h22}) begin
            failures++; $display("FAIL sec_second got=%b/%0d/%h exp=1/8/22", o_rd_wen, o_rd_waddr, o_rd_wdata);
        end
        tick();
        checks++;
        if ({o_rd_wen, o_s_ready} !== 2'b01) begin
            failures++; $display("FAIL sec_empty wen/ready got=%b exp=01", {o_rd_wen, o_s_ready});
        end
    endtask

    task automatic test_starvation();
        do_reset();
        i_p_valid = 1'b1; i_p_rd = 5'd1; i_p_data = 32'd101;
        i_s_valid = 1'b1; i_s_rd = 5'd9; i_s_data = 32'h99;
        tick();
        i_s_valid = 1'b0;
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata, o_p_stall} !== {1'b1, 5'd1, 32'd101, 1'b0}) begin
            failures++; $display("FAIL starve_p1 got=%b/%0d/%0d stall=%b", o_rd_wen, o_rd_waddr, o_rd_wdata, o_p_stall);
        end
        // Four primary grants with the FIFO occupied; the fourth triggers the forced slot.
        for (int k = 2; k <= 5; k++) begin
            i_p_rd = 5'(k); i_p_data = 32'(100 + k);
            tick();
            checks++;
            if ({o_rd_wen, o_rd_waddr, o_rd_wdata, o_p_stall} !== {1'b1, 5'(k), 32'(100 + k), (k == 5)}) begin
                failures++;
                $display("FAIL starve_p%0d got=%b/%0d/%0d stall=%b exp stall=%b",
                         k, o_rd_wen, o_rd_waddr, o_rd_wdata, o_p_stall, (k == 5));
            end
        end
        i_p_rd = 5'd6; i_p_data = 32'd106;
        tick();
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata, o_p_stall} !== {1'b1, 5'd9, 32'h99, 1'b0}) begin
            failures++; $display("FAIL starve_forced got=%b/%0d/%h stall=%b exp=1/9/99 stall=0", o_rd_wen, o_rd_waddr, o_rd_wdata, o_p_stall);
        end
        tick();
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b1, 5'd6, 32'd106}) begin
            failures++; $display("FAIL starve_held_p got=%b/%0d/%0d exp=1/6/106", o_rd_wen, o_rd_waddr, o_rd_wdata);
        end
        idle_inputs();
        tick();
        checks++;
        if ({o_rd_wen, o_p_stall} !== 2'b00) begin
            failures++; $display("FAIL starve_tail wen/stall got=%b exp=00", {o_rd_wen, o_p_stall});
        end
    endtask

    task automatic test_full();
        do_reset();
        i_p_valid = 1'b1; i_p_rd = 5'd10; i_p_data = 32'h10;
        i_s_valid = 1'b1; i_s_rd = 5'd11; i_s_data = 32'hA1;
        tick();
        i_s_rd = 5'd12; i_s_data = 32'hB2;
        checks++;
        if (o_s_ready !== 1'b1) begin
            failures++; $display("FAIL full_ready1 got=%b exp=1", o_s_ready);
        end
        tick();
        checks++;
        if (o_s_ready !== 1'b0) begin
            failures++; $display("FAIL full_ready_after2 got=%b exp=0", o_s_ready);
        end
        i_s_rd = 5'd13; i_s_data = 32'hC3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({o_s_ready, o_p_stall} !== {1'b0, (i == 2)}) begin
                failures++; $display("FAIL full_hold cyc=%0d ready/stall got=%b exp=0%b", i, {o_s_ready, o_p_stall}, (i == 2));
            end
        end
        tick();
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata, o_s_ready} !== {1'b1, 5'd11, 32'hA1, 1'b1}) begin
            failures++; $display("FAIL full_popA got=%b/%0d/%h ready=%b exp=1/11/a1 ready=1", o_rd_wen, o_rd_waddr, o_rd_wdata, o_s_ready);
        end
        tick();
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b1, 5'd10, 32'h10}) begin
            failures++; $display("FAIL full_primary got=%b/%0d/%h exp=1/10/10", o_rd_wen, o_rd_waddr, o_rd_wdata);
        end
        idle_inputs();
        tick();
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b1, 5'd12, 32'hB2}) begin
            failures++; $display("FAIL full_popB got=%b/%0d/%h exp=1/12/b2", o_rd_wen, o_rd_waddr, o_rd_wdata);
        end
        tick();
        checks++;
        if ({o_rd_wen, o_rd_waddr, o_rd_wdata} !== {1'b1, 5'd13, 32'hC3}) begin
            failures++; $display("FAIL full_popC got=%b/%0d/%h exp=1/13/c3", o_rd_wen, o_rd_waddr, o_rd_wdata);
        end
        tick();
        checks++;
        if ({o_rd_wen, o_s_ready} !== 2'b01) begin
            failures++; $display("FAIL full_drained got=%b exp=01", {o_rd_wen, o_s_ready});
        end
    endtask

    task automatic test_wrap();
        logic [4:0]  q_rd [$];
        logic [31:0] q_data [$];
        logic [4:0]  last_addr = 5'd0;
        logic [4:0]  er;
        logic [31:0] last_data = 32'd0;
        logic [31:0] ed;
        logic [37:0] exp_v;
        do_reset();
        for (int i = 0; i <= 10; i++) begin
            if (i < 10) begin
                i_s_valid = 1'b1;
                i_s_rd    = 5'($urandom_range(31, 0));
                i_s_data  = $urandom;
                q_rd.push_back(i_s_rd);
                q_data.push_back(i_s_data);
            end else begin
                i_s_valid = 1'b0;
            end
            tick();
            if (i > 0) begin
                er = q_rd.pop_front();
                ed = q_data.pop_front();
                if (er != 5'd0) begin
                    last_addr = er;
                    last_data = ed;
                    exp_v = {1'b1, er, ed};
                end else begin
                    exp_v = {1'b0, last_addr, last_data};
                end
                checks++;
                if ({o_rd_wen, o_rd_waddr, o_rd_wdata} !== exp_v) begin
                    failures++;
                    $display("FAIL wrap_%0d got=%b/%0d/%h exp=%b/%0d/%h", i, o_rd_wen, o_rd_waddr, o_rd_wdata,
                             exp_v[37], exp_v[36:32], exp_v[31:0]);
                end
            end
        end
        tick();
        checks++;
        if (o_rd_wen !== 1'b0) begin
            failures++; $display("FAIL wrap_empty wen got=%b exp=0", o_rd_wen);
        end
    endtask

    initial begin
        test_reset();
        test_primary();
        test_secondary();
        test_starvation();
        test_full();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
